// File: rtl/mem_dump_ser.sv
// Byte serializer for the memory dump path: one 8N1 frame per load.
// ready is high while idle and during the final cycle of the stop bit.
module mem_dump_ser #(
  parameter int SERIAL_WCNT = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       load,
  output logic       txd,
  output logic       ready
);

  localparam int FRAME_BITS = 10;
  localparam int CW = $clog2(SERIAL_WCNT);

  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [8:0]    sh;
  logic          active;
  logic          last;

  assign last  = (cnt == CW'(SERIAL_WCNT - 1));
  assign ready = !active ||
                 (last && bit_idx == 4'(FRAME_BITS - 1));

  // sh holds {stop, data}; the start bit is driven directly on load
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '1;
      txd     <= 1'b1;
    end else if (load) begin
      active  <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= {1'b1, data};
      txd     <= 1'b0;
    end else if (active) begin
      if (last) begin
        cnt <= '0;
        if (bit_idx == 4'(FRAME_BITS - 1)) begin
          active <= 1'b0;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          txd     <= sh[0];
          sh      <= {1'b1, sh[8:1]};
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_dump_tx.sv
// Memory-to-host unloader: reads words from a memory read port
// and ships them little-endian over its own UART serializer.
module mem_dump_tx #(
  parameter int SERIAL_WCNT = 100,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          base_addr,
  input  logic [CNT_WIDTH-1:0] word_cnt,
  output logic                 mem_oe,
  output logic [31:0]          mem_addr,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_valid,
  output logic                 txd,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SEND,
    S_FIN
  } state_t;

  state_t               state, state_n;
  logic [CNT_WIDTH-1:0] cnt;
  logic [31:0]          word;
  logic [2:0]           byte_idx;
  logic                 load;
  logic [7:0]           ser_data;
  logic                 ser_ready;

  mem_dump_ser #(
    .SERIAL_WCNT(SERIAL_WCNT)
  ) u_ser (
    .clk  (clk),
    .rst  (rst),
    .data (ser_data),
    .load (load),
    .txd  (txd),
    .ready(ser_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // byte0 is loaded straight from mem_rdata so its start bit
  // begins in the cycle after mem_valid
  always_comb begin
    state_n  = state;
    load     = 1'b0;
    ser_data = 8'h00;
    unique case (state)
      S_IDLE: begin
        if (start)
          state_n = (word_cnt == '0) ? S_FIN : S_REQ;
      end
      S_REQ: state_n = S_WAIT;
      S_WAIT: begin
        if (mem_valid) begin
          load     = 1'b1;
          ser_data = mem_rdata[7:0];
          state_n  = S_SEND;
        end
      end
      S_SEND: begin
        if (ser_ready) begin
          if (byte_idx == 3'd4) begin
            state_n = (cnt == CNT_WIDTH'(1)) ? S_FIN : S_REQ;
          end else begin
            load     = 1'b1;
            ser_data = word[{byte_idx[1:0], 3'b000} +: 8];
          end
        end
      end
      S_FIN: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_oe   <= 1'b0;
      mem_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      word     <= '0;
      byte_idx <= '0;
    end else begin
      mem_oe <= (state_n == S_REQ);
      done   <= (state == S_FIN);
      unique case (state)
        S_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            mem_addr <= base_addr & 32'hFFFF_FFFC;
            cnt      <= word_cnt;
          end
        end
        S_WAIT: begin
          if (mem_valid) begin
            word     <= mem_rdata;
            byte_idx <= 3'd1;
          end
        end
        S_SEND: begin
          if (ser_ready) begin
            if (byte_idx == 3'd4) begin
              mem_addr <= mem_addr + 32'd4;
              cnt      <= cnt - CNT_WIDTH'(1);
            end else begin
              byte_idx <= byte_idx + 3'd1;
            end
          end
        end
        S_FIN: busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_tx.sv
// Scoreboard bench for mem_dump_tx: memory responder, UART
// frame decoder and address/done monitors against queued expectations.
module tb_mem_dump_tx;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] word_cnt = '0;
  logic        mem_oe;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_valid = 1'b0;
  logic        txd;
  logic        busy;
  logic        done;

  mem_dump_tx #(
    .SERIAL_WCNT(W),
    .CNT_WIDTH  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .word_cnt (word_cnt),
    .mem_oe   (mem_oe),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_valid(mem_valid),
    .txd      (txd),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(bit ok, string name,
                              logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t",
               name, act, exp, $time);
    end
  endfunction

  logic [31:0] mem_ovr [logic [31:0]];

  function automatic logic [31:0] memw(logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  logic [31:0] exp_addr[$];
  logic [7:0]  exp_byte[$];
  int          lat_q[$];
  int          done_cnt = 0;
  int          done_exp = 0;
  int          nframes = 0;

  // memory responder
  initial begin
    logic [31:0] a;
    int          lat;
    forever begin
      @(negedge clk);
      if (mem_oe && !rst) begin
        a   = mem_addr;
        lat = (lat_q.size() != 0) ? lat_q.pop_front()
                                  : int'($urandom_range(1, 5));
        repeat (lat) @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_rdata = memw(a);
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        mem_rdata = $urandom;
        @(negedge clk);
        chk(txd == 1'b0, "start_after_valid", 32'(txd), 0);
      end
    end
  end

  // address, done and UART frame monitor
  initial begin
    bit          in_frame = 0;
    bit          b2b = 0;
    bit          prev_oe = 0;
    bit          cur = 0;
    int          pos = 0;
    int          wb = 0;
    logic [9:0]  fb = '0;
    logic [31:0] e;
    logic [7:0]  eb;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 0;
        b2b      = 0;
        prev_oe  = 0;
        wb       = 0;
      end else begin
        if (mem_oe) begin
          chk(!prev_oe, "oe_single_cycle", 32'(prev_oe), 0);
          chk(exp_addr.size() != 0, "oe_expected", mem_addr, 0);
          if (exp_addr.size() != 0) begin
            e = exp_addr.pop_front();
            chk(mem_addr == e, "mem_addr", mem_addr, e);
          end
        end
        prev_oe = mem_oe;
        if (done) begin
          done_cnt++;
          chk(busy == 1'b0, "busy_falls_with_done", 32'(busy), 0);
        end
        if (!in_frame) begin
          if (b2b) begin
            chk(txd == 1'b0, "back_to_back", 32'(txd), 0);
            b2b = 0;
          end
          if (txd == 1'b0) begin
            in_frame = 1;
            pos      = 0;
          end
        end
        if (in_frame) begin
          if (pos % W == 0) cur = txd;
          else chk(txd == cur, "bit_width", 32'(txd), 32'(cur));
          if (pos % W == W - 1) fb[pos / W] = cur;
          pos++;
          if (pos == 10 * W) begin
            in_frame = 0;
            nframes++;
            chk(fb[0] == 1'b0, "start_bit", 32'(fb[0]), 0);
            chk(fb[9] == 1'b1, "stop_bit", 32'(fb[9]), 1);
            chk(exp_byte.size() != 0, "byte_expected", 32'(fb[8:1]), 0);
            if (exp_byte.size() != 0) begin
              eb = exp_byte.pop_front();
              chk(fb[8:1] == eb, "byte", 32'(fb[8:1]), 32'(eb));
            end
            wb  = (wb + 1) % 4;
            b2b = (wb != 0);
          end
        end
      end
    end
  end

  task automatic do_start(input logic [31:0] base, input int cnt);
    logic [31:0] a;
    logic [31:0] w;
    for (int i = 0; i < cnt; i++) begin
      a = (base & 32'hFFFF_FFFC) + 32'(4 * i);
      exp_addr.push_back(a);
      w = memw(a);
      for (int b = 0; b < 4; b++) exp_byte.push_back(w[8*b +: 8]);
    end
    done_exp++;
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = base;
    word_cnt  = 16'(cnt);
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = $urandom;
    word_cnt  = 16'($urandom);
    @(negedge clk);
    chk(busy == 1'b1, "busy_after_start", 32'(busy), 1);
    if (cnt == 0) begin
      chk(mem_oe == 1'b0, "zero_no_oe", 32'(mem_oe), 0);
      chk(done == 1'b0, "zero_done_early", 32'(done), 0);
      @(negedge clk);
      chk(done == 1'b1, "zero_done_latency", 32'(done), 1);
      chk(txd == 1'b1, "zero_txd_idle", 32'(txd), 1);
    end else begin
      chk(mem_oe == 1'b1, "oe_latency", 32'(mem_oe), 1);
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (done_cnt < done_exp && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk(done_cnt == done_exp, "done_count", done_cnt, done_exp);
    repeat (3) @(negedge clk);
    chk(done_cnt == done_exp, "done_once", done_cnt, done_exp);
    chk(exp_byte.size() == 0, "bytes_left", exp_byte.size(), 0);
    chk(exp_addr.size() == 0, "addrs_left", exp_addr.size(), 0);
    chk(busy == 1'b0, "busy_idle", 32'(busy), 0);
    chk(txd == 1'b1, "txd_idle", 32'(txd), 1);
  endtask

  initial begin
    int n0;
    int k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(txd == 1'b1, "rst_txd", 32'(txd), 1);
    chk(busy == 1'b0, "rst_busy", 32'(busy), 0);
    chk(mem_oe == 1'b0, "rst_oe", 32'(mem_oe), 0);
    chk(done == 1'b0, "rst_done", 32'(done), 0);
    chk(mem_addr == 32'h0, "rst_addr", mem_addr, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    mem_ovr[32'h100] = 32'hA55A_1234;
    lat_q.push_back(2);
    do_start(32'h100, 1);
    wait_done();

    lat_q.push_back(1);
    lat_q.push_back(5);
    lat_q.push_back(2);
    do_start(32'hFFC, 3);
    wait_done();

    do_start(32'h40, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk(txd == 1'b1, "zero_txd_stays", 32'(txd), 1);
    end
    wait_done();

    n0 = nframes;
    do_start(32'h2000, 2);
    k = 0;
    while (nframes < n0 + 1 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    chk(nframes >= n0 + 1, "disturb_wait", nframes, n0 + 1);
    repeat (3) @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = 32'h5000;
    word_cnt  = 16'd7;
    @(posedge clk);
    #1;
    start     = 1'b0;
    @(posedge clk);
    #1;
    mem_valid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    wait_done();

    n0 = nframes;
    do_start(32'h300, 2);
    k = 0;
    while (nframes < n0 + 1 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    chk(nframes == n0 + 1, "reset_wait", nframes, n0 + 1);
    repeat (17) @(posedge clk);
    #1 rst = 1'b1;
    exp_byte.delete();
    exp_addr.delete();
    done_exp--;
    @(posedge clk);
    @(negedge clk);
    chk(txd == 1'b1, "abort_txd", 32'(txd), 1);
    chk(busy == 1'b0, "abort_busy", 32'(busy), 0);
    chk(mem_oe == 1'b0, "abort_oe", 32'(mem_oe), 0);
    chk(done == 1'b0, "abort_done", 32'(done), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk(done_cnt == done_exp, "abort_no_done", done_cnt, done_exp);
    do_start(32'h300, 2);
    wait_done();

    do_start(32'hFFFF_FFFF, 2);
    wait_done();

    for (int i = 0; i < 4; i++) begin
      do_start($urandom, int'($urandom_range(1, 2)));
      wait_done();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
